// File: rtl/axil_slave_ctrl_if.sv
// AXI4-Lite bus bundle between host/bench (master) and axil_slave_ctrl (slave).
// A channel transfers on every rising clk edge where valid && ready; the source holds payload stable while valid is high.
interface axil_slave_ctrl_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_slave_ctrl.sv
// AXI4-Lite responder turning each transaction into one single-issue cfg register-bus access.
// Optional read timeout with SLVERR response: define AXIL_SLAVE_TIMEOUT_EN.
module axil_slave_ctrl #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    axil_slave_ctrl_if.slave      axi4_slave,
    output logic                  cfg_wr_en,
    output logic [ADDR_WIDTH-1:0] cfg_wr_addr,
    output logic [DATA_WIDTH-1:0] cfg_wr_data,
    output logic                  cfg_rd_en,
    output logic [ADDR_WIDTH-1:0] cfg_rd_addr,
    input  logic [DATA_WIDTH-1:0] cfg_rd_data,
    input  logic                  cfg_rd_data_valid,
    output logic [1:0]            dbg_wr_state,
    output logic [1:0]            dbg_rd_state
);
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ISSUE = 2'd1, W_RESP = 2'd2} wr_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ISSUE = 2'd1, R_WAIT = 2'd2, R_RESP = 2'd3} rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    wr_state_t             wr_state;
    rd_state_t             rd_state;
    logic                  awready_q, wready_q, bvalid_q;
    logic                  aw_held, w_held;
    logic                  arready_q, rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  aw_fire, w_fire, aw_have, w_have, wr_go, ar_fire;

    assign aw_fire = axi4_slave.awvalid & awready_q;
    assign w_fire  = axi4_slave.wvalid & wready_q;
    assign aw_have = aw_held | aw_fire;
    assign w_have  = w_held | w_fire;
    assign wr_go   = (wr_state == W_IDLE) & aw_have & w_have;
    assign ar_fire = axi4_slave.arvalid & arready_q;

    assign axi4_slave.awready = awready_q;
    assign axi4_slave.wready  = wready_q;
    assign axi4_slave.bvalid  = bvalid_q;
    assign axi4_slave.bresp   = RESP_OKAY;
    assign axi4_slave.arready = arready_q;
    assign axi4_slave.rvalid  = rvalid_q;
    assign axi4_slave.rdata   = rdata_q;
    assign axi4_slave.rresp   = rresp_q;
    assign dbg_wr_state       = wr_state;
    assign dbg_rd_state       = rd_state;

    // cfg_wr_addr/cfg_wr_data double as the AW/W holding registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state    <= W_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            bvalid_q    <= 1'b0;
            cfg_wr_en   <= 1'b0;
            cfg_wr_addr <= '0;
            cfg_wr_data <= '0;
        end else begin
            cfg_wr_en <= 1'b0;
            case (wr_state)
                W_IDLE: begin
                    if (aw_fire) cfg_wr_addr <= axi4_slave.awaddr;
                    if (w_fire)  cfg_wr_data <= axi4_slave.wdata;
                    if (wr_go) begin
                        wr_state  <= W_ISSUE;
                        cfg_wr_en <= 1'b1;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                    end else begin
                        aw_held   <= aw_have;
                        w_held    <= w_have;
                        awready_q <= ~aw_have;
                        wready_q  <= ~w_have;
                    end
                end
                W_ISSUE: begin
                    wr_state <= W_RESP;
                    bvalid_q <= 1'b1;
                end
                W_RESP: begin
                    if (axi4_slave.bready) begin
                        bvalid_q  <= 1'b0;
                        wr_state  <= W_IDLE;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

`ifdef AXIL_SLAVE_TIMEOUT_EN
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
    logic [CNT_W-1:0] rd_cnt;
`endif

    // A read entering R_ISSUE alongside a write stays there one extra cycle before strobing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state    <= R_IDLE;
            arready_q   <= 1'b0;
            cfg_rd_en   <= 1'b0;
            cfg_rd_addr <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
`ifdef AXIL_SLAVE_TIMEOUT_EN
            rd_cnt      <= '0;
`endif
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        cfg_rd_addr <= axi4_slave.araddr;
                        arready_q   <= 1'b0;
                        rd_state    <= R_ISSUE;
                        cfg_rd_en   <= ~wr_go;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_ISSUE: begin
                    if (cfg_rd_en) begin
                        cfg_rd_en <= 1'b0;
                        rd_state  <= R_WAIT;
`ifdef AXIL_SLAVE_TIMEOUT_EN
                        rd_cnt    <= '0;
`endif
                    end else begin
                        cfg_rd_en <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (cfg_rd_data_valid) begin
                        rdata_q  <= cfg_rd_data;
                        rresp_q  <= RESP_OKAY;
                        rvalid_q <= 1'b1;
                        rd_state <= R_RESP;
`ifdef AXIL_SLAVE_TIMEOUT_EN
                    end else if (rd_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                        rdata_q  <= DATA_WIDTH'(32'hDEAD_BEEF);
                        rresp_q  <= RESP_SLVERR;
                        rvalid_q <= 1'b1;
                        rd_state <= R_RESP;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
`endif
                    end
                end
                R_RESP: begin
                    if (axi4_slave.rready) begin
                        rvalid_q  <= 1'b0;
                        rd_state  <= R_IDLE;
                        arready_q <= 1'b1;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_slave_ctrl.sv
// Directed bench for axil_slave_ctrl; timeout scenario runs only when AXIL_SLAVE_TIMEOUT_EN is defined.
module tb_axil_slave_ctrl;
    localparam int AW         = 13;
    localparam int DW         = 32;
    localparam int RD_TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_wr_en, cfg_rd_en;
    logic [AW-1:0] cfg_wr_addr, cfg_rd_addr;
    logic [DW-1:0] cfg_wr_data, cfg_rd_data;
    logic          cfg_rd_data_valid;
    logic [1:0]    dbg_wr_state, dbg_rd_state;

    int n_checks  = 0;
    int n_errors  = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int n;

    logic [AW+DW-1:0] exp_wr_q[$];
    logic [AW-1:0]    exp_rd_q[$];

    axil_slave_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi4_slave ();

    axil_slave_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .axi4_slave        (axi4_slave.slave),
        .cfg_wr_en         (cfg_wr_en),
        .cfg_wr_addr       (cfg_wr_addr),
        .cfg_wr_data       (cfg_wr_data),
        .cfg_rd_en         (cfg_rd_en),
        .cfg_rd_addr       (cfg_rd_addr),
        .cfg_rd_data       (cfg_rd_data),
        .cfg_rd_data_valid (cfg_rd_data_valid),
        .dbg_wr_state      (dbg_wr_state),
        .dbg_rd_state      (dbg_rd_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int cycles = 1);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic start_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        axi4_slave.awaddr  = addr;
        axi4_slave.wdata   = data;
        axi4_slave.awvalid = 1'b1;
        axi4_slave.wvalid  = 1'b1;
        exp_wr_q.push_back({addr, data});
    endtask

    task automatic start_read(input logic [AW-1:0] addr);
        axi4_slave.araddr  = addr;
        axi4_slave.arvalid = 1'b1;
        exp_rd_q.push_back(addr);
    endtask

    task automatic drop_valids();
        axi4_slave.awvalid = 1'b0;
        axi4_slave.wvalid  = 1'b0;
        axi4_slave.arvalid = 1'b0;
    endtask

    task automatic rd_data_pulse(input logic [DW-1:0] data);
        cfg_rd_data       = data;
        cfg_rd_data_valid = 1'b1;
        step();
        cfg_rd_data_valid = 1'b0;
        cfg_rd_data       = '0;
    endtask

    // scoreboard on the register bus
    always @(negedge clk) begin
        if (reset_n) begin
            if (cfg_wr_en) begin
                wr_pulses++;
                check("rd_en_during_wr_en", cfg_rd_en, 1'b0);
                check("wr_expected", exp_wr_q.size() != 0, 1'b1);
                if (exp_wr_q.size() != 0) check("wr_addr_data", {cfg_wr_addr, cfg_wr_data}, exp_wr_q.pop_front());
            end
            if (cfg_rd_en) begin
                rd_pulses++;
                check("rd_expected", exp_rd_q.size() != 0, 1'b1);
                if (exp_rd_q.size() != 0) check("rd_addr", cfg_rd_addr, exp_rd_q.pop_front());
            end
        end
    end

    initial begin
        axi4_slave.awaddr  = '0;
        axi4_slave.awvalid = 1'b0;
        axi4_slave.wdata   = '0;
        axi4_slave.wvalid  = 1'b0;
        axi4_slave.bready  = 1'b0;
        axi4_slave.araddr  = '0;
        axi4_slave.arvalid = 1'b0;
        axi4_slave.rready  = 1'b0;
        cfg_rd_data        = '0;
        cfg_rd_data_valid  = 1'b0;

        #12;
        check("rst_ready", {axi4_slave.awready, axi4_slave.wready, axi4_slave.arready}, 3'b000);
        check("rst_resp", {axi4_slave.bvalid, axi4_slave.bresp, axi4_slave.rvalid, axi4_slave.rresp}, 6'd0);
        check("rst_rdata", axi4_slave.rdata, 32'd0);
        check("rst_cfg", {cfg_wr_en, cfg_rd_en, cfg_wr_addr, cfg_rd_addr, cfg_wr_data}, '0);
        check("rst_state", {dbg_wr_state, dbg_rd_state}, 4'd0);
        reset_n = 1'b1;
        step();
        check("idle_ready", {axi4_slave.awready, axi4_slave.wready, axi4_slave.arready}, 3'b111);

        // 1: AW+W same cycle
        axi4_slave.bready = 1'b1;
        start_write(13'h0010, 32'hA5A5_0001);
        step();
        drop_valids();
        check("t1_wr_en", cfg_wr_en, 1'b1);
        check("t1_awready_low", axi4_slave.awready, 1'b0);
        check("t1_no_bvalid_yet", axi4_slave.bvalid, 1'b0);
        step();
        check("t1_wr_en_one_cycle", cfg_wr_en, 1'b0);
        check("t1_bvalid", {axi4_slave.bvalid, axi4_slave.bresp}, 3'b100);
        step();
        check("t1_b_done", axi4_slave.bvalid, 1'b0);
        check("t1_ready_again", {axi4_slave.awready, axi4_slave.wready}, 2'b11);

        // 2: W three cycles ahead of AW, then a stalled B
        axi4_slave.bready = 1'b0;
        axi4_slave.wdata  = 32'h1234_5678;
        axi4_slave.wvalid = 1'b1;
        exp_wr_q.push_back({13'h0104, 32'h1234_5678});
        step();
        axi4_slave.wvalid = 1'b0;
        check("t2_wready_drop", {axi4_slave.wready, axi4_slave.awready}, 2'b01);
        step(2);
        check("t2_wready_held", axi4_slave.wready, 1'b0);
        check("t2_no_early_issue", cfg_wr_en, 1'b0);
        axi4_slave.awaddr  = 13'h0104;
        axi4_slave.awvalid = 1'b1;
        step();
        axi4_slave.awvalid = 1'b0;
        check("t2_wr_en", cfg_wr_en, 1'b1);
        step();
        check("t2_bvalid", {axi4_slave.bvalid, axi4_slave.bresp, cfg_wr_en}, 4'b1000);
        step(2);
        check("t2_bvalid_stall", {axi4_slave.bvalid, axi4_slave.bresp}, 3'b100);
        check("t2_no_new_aw", {axi4_slave.awready, axi4_slave.wready}, 2'b00);
        axi4_slave.bready = 1'b1;
        step();
        check("t2_b_done", axi4_slave.bvalid, 1'b0);
        check("t2_wr_pulses", wr_pulses, 2);

        // misaligned write passes low bits through with OKAY
        start_write(13'h0107, 32'h0BAD_0107);
        step();
        drop_valids();
        check("mis_addr", cfg_wr_addr, 13'h0107);
        step();
        check("mis_bresp", {axi4_slave.bvalid, axi4_slave.bresp}, 3'b100);
        step();

        // 3: read with data 2 cycles after strobe and rready held low
        axi4_slave.rready = 1'b0;
        start_read(13'h0020);
        step();
        drop_valids();
        check("t3_rd_en", {cfg_rd_en, axi4_slave.arready}, 2'b10);
        step();
        check("t3_wait", {cfg_rd_en, axi4_slave.rvalid}, 2'b00);
        step();
        rd_data_pulse(32'hCAFE_F00D);
        for (int i = 0; i < 4; i++) begin
            check("t3_rvalid_hold", {axi4_slave.rvalid, axi4_slave.rresp}, 3'b100);
            check("t3_rdata_hold", axi4_slave.rdata, 32'hCAFE_F00D);
            step();
        end
        axi4_slave.rready = 1'b1;
        step();
        axi4_slave.rready = 1'b0;
        check("t3_r_done", {axi4_slave.rvalid, axi4_slave.arready}, 2'b01);

        // stray cfg_rd_data_valid while idle is ignored
        rd_data_pulse(32'h7777_7777);
        check("stray_ignored", {axi4_slave.rvalid, dbg_rd_state}, 3'b000);

        // 4: write and read arrive together
        start_write(13'h0200, 32'h00C0_FFEE);
        start_read(13'h0024);
        step();
        drop_valids();
        check("t4_write_first", {cfg_wr_en, cfg_rd_en}, 2'b10);
        step();
        check("t4_read_second", {cfg_wr_en, cfg_rd_en, axi4_slave.bvalid}, 3'b011);
        step();
        check("t4_bus_quiet", {cfg_wr_en, cfg_rd_en, axi4_slave.bvalid}, 3'b000);
        rd_data_pulse(32'h1111_2222);
        check("t4_rdata", {axi4_slave.rvalid, axi4_slave.rresp, axi4_slave.rdata}, {3'b100, 32'h1111_2222});
        axi4_slave.rready = 1'b1;
        step();
        axi4_slave.rready = 1'b0;
        check("t4_r_done", axi4_slave.rvalid, 1'b0);

        // 5: reset during R_WAIT
        start_read(13'h0040);
        step();
        drop_valids();
        step();
        check("t5_in_wait", dbg_rd_state, 2'd2);
        #2 reset_n = 1'b0;
        #1;
        check("t5_async_rd", {axi4_slave.arready, axi4_slave.rvalid, cfg_rd_en, dbg_rd_state}, 5'd0);
        check("t5_async_wr", {axi4_slave.awready, axi4_slave.wready, axi4_slave.bvalid, cfg_rd_addr}, '0);
        step();
        reset_n = 1'b1;
        step();
        check("t5_arready", axi4_slave.arready, 1'b1);
        start_read(13'h0030);
        step();
        drop_valids();
        check("t5_rd_en", {cfg_rd_en, cfg_rd_addr}, {1'b1, 13'h0030});
        step();
        rd_data_pulse(32'h3030_3030);
        check("t5_rdata", {axi4_slave.rvalid, axi4_slave.rresp, axi4_slave.rdata}, {3'b100, 32'h3030_3030});
        axi4_slave.rready = 1'b1;
        step();
        axi4_slave.rready = 1'b0;
        check("t5_r_done", axi4_slave.rvalid, 1'b0);

`ifdef AXIL_SLAVE_TIMEOUT_EN
        // 6: no cfg_rd_data_valid -> SLVERR after RD_TIMEOUT
        start_read(13'h0050);
        step();
        drop_valids();
        n = 1;
        while (!axi4_slave.rvalid && n < 100) begin
            step();
            n++;
        end
        check("t6_latency", n, RD_TIMEOUT + 2);
        check("t6_resp", {axi4_slave.rresp, axi4_slave.rdata}, {2'b10, 32'hDEAD_BEEF});
        rd_data_pulse(32'h1212_1212);
        check("t6_late_dropped", {axi4_slave.rvalid, axi4_slave.rdata}, {1'b1, 32'hDEAD_BEEF});
        axi4_slave.rready = 1'b1;
        step();
        axi4_slave.rready = 1'b0;
        check("t6_r_done", axi4_slave.rvalid, 1'b0);
        check("rd_pulses", rd_pulses, 5);
`else
        n = 0;
        check("rd_pulses", rd_pulses, 4);
`endif

        // final report
        check("wr_pulses", wr_pulses, 4);
        check("wr_q_drained", exp_wr_q.size(), 0);
        check("rd_q_drained", exp_rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
